// File: rtl/mio_bus.sv
// mio_bus: memory-mapped I/O bus controller sitting behind the CPU wrapper.
// Decodes CPU accesses onto a synchronous data RAM (region 0x0), a GPIO
// register pair (region 0xE) and an optional down-counter (region 0xF).
// Returns registered read data with a one-cycle MIO_ready completion pulse.
// Build option: define MIO_COUNTER_EN to build the counter and its interrupt;
// without it region 0xF is unmapped and INT is tied low.

module mio_bus #(
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req,
  input  logic              mem_w,
  input  logic [31:0]       Addr_out,
  input  logic [31:0]       Data_out,
  output logic [31:0]       Data_in,
  output logic              MIO_ready,
  output logic              INT,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [31:0]       gpio_in,
  output logic [31:0]       gpio_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAM_RD = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic        r_ready;
  logic [31:0] r_dataIn;
  logic [31:0] r_gpioOut;

  logic [3:0]  w_region;
  logic [27:0] w_offset;
  logic        w_isRam;
  logic        w_isGpioOut;
  logic        w_isGpioIn;
  logic        w_isCount;
  logic        w_isCtrl;
  logic        w_access;
  logic        w_wrStrobe;
  logic        w_regRdStrobe;
  logic [31:0] w_regRdata;
  logic [31:0] w_countRdata;
  logic [31:0] w_ctrlRdata;

  // ---------------------------------------------------------------------
  // Address decode. Register regions decode the full 28-bit offset so that
  // stray offsets inside a region behave like unmapped space.
  // ---------------------------------------------------------------------
  assign w_region    = Addr_out[31:28];
  assign w_offset    = Addr_out[27:0];
  assign w_isRam     = (w_region == 4'h0);
  assign w_isGpioOut = (w_region == 4'hE) && (w_offset == 28'h0);
  assign w_isGpioIn  = (w_region == 4'hE) && (w_offset == 28'h4);

  // Only IDLE samples the request; changes while busy are ignored.
  assign w_access      = (r_state == IDLE) && mem_req;
  assign w_wrStrobe    = w_access && mem_w;
  assign w_regRdStrobe = w_access && !mem_w && !w_isRam;

  // RAM side is a straight pass-through; the strobe is gated by reset so a
  // request held across reset can never reach the RAM.
  assign ram_addr = Addr_out[RAM_AW+1:2];
  assign ram_din  = Data_out;
  assign ram_we   = reset && w_wrStrobe && w_isRam;

  assign Data_in   = r_dataIn;
  assign MIO_ready = r_ready;
  assign gpio_out  = r_gpioOut;

  // Next-state logic: RAM reads need an extra cycle for the RAM latency.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (mem_req) begin
          if (w_isRam && !mem_w) begin
            w_nextState = RAM_RD;
          end else begin
            w_nextState = RESP;
          end
        end
      end
      RAM_RD:  w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register plus the completion pulse, which is high exactly in RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_ready <= (w_nextState == RESP);
    end
  end

  // Register read mux; anything not matched reads as zero.
  always_comb begin
    w_regRdata = 32'h0;
    if (w_isGpioOut) begin
      w_regRdata = r_gpioOut;
    end else if (w_isGpioIn) begin
      w_regRdata = gpio_in;
    end else if (w_isCount) begin
      w_regRdata = w_countRdata;
    end else if (w_isCtrl) begin
      w_regRdata = w_ctrlRdata;
    end
  end

  // Read data capture: RAM data one cycle after the address, register data
  // on the IDLE->RESP edge. Writes leave the last read value untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dataIn <= 32'h0;
    end else if (r_state == RAM_RD) begin
      r_dataIn <= ram_dout;
    end else if (w_regRdStrobe) begin
      r_dataIn <= w_regRdata;
    end
  end

  // GPIO output register; writes to the input offset fall through and drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gpioOut <= 32'h0;
    end else if (w_wrStrobe && w_isGpioOut) begin
      r_gpioOut <= Data_out;
    end
  end

`ifdef MIO_COUNTER_EN
  logic [31:0] r_count;
  logic [31:0] r_reload;
  logic        r_en;
  logic        r_auto;
  logic        r_pend;
  logic        r_ie;
  logic        r_int;
  logic        w_countWr;
  logic        w_ctrlWr;
  logic        w_underflow;

  assign w_isCount    = (w_region == 4'hF) && (w_offset == 28'h0);
  assign w_isCtrl     = (w_region == 4'hF) && (w_offset == 28'h4);
  assign w_countWr    = w_wrStrobe && w_isCount;
  assign w_ctrlWr     = w_wrStrobe && w_isCtrl;
  assign w_underflow  = r_en && (r_count == 32'h0);
  assign w_countRdata = r_count;
  assign w_ctrlRdata  = {28'h0, r_ie, r_pend, r_auto, r_en};
  assign INT          = r_int;

  // COUNT/RELOAD: a CPU write beats both the decrement and the auto-reload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count  <= 32'h0;
      r_reload <= 32'h0;
    end else if (w_countWr) begin
      r_count  <= Data_out;
      r_reload <= Data_out;
    end else if (r_en) begin
      if (r_count != 32'h0) begin
        r_count <= r_count - 32'd1;
      end else if (r_auto) begin
        r_count <= r_reload;
      end
    end
  end

  // CTRL: CPU writes win for EN, but an underflow always sets PEND even if
  // the same write tries to clear it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en   <= 1'b0;
      r_auto <= 1'b0;
      r_pend <= 1'b0;
      r_ie   <= 1'b0;
    end else begin
      if (w_ctrlWr) begin
        r_en   <= Data_out[0];
        r_auto <= Data_out[1];
        r_ie   <= Data_out[3];
      end else if (w_underflow && !r_auto) begin
        r_en <= 1'b0;
      end
      if (w_underflow) begin
        r_pend <= 1'b1;
      end else if (w_ctrlWr && Data_out[2]) begin
        r_pend <= 1'b0;
      end
    end
  end

  // Interrupt line, one cycle behind PEND/IE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_int <= 1'b0;
    end else begin
      r_int <= r_pend && r_ie;
    end
  end
`else
  assign w_isCount    = 1'b0;
  assign w_isCtrl     = 1'b0;
  assign w_countRdata = 32'h0;
  assign w_ctrlRdata  = 32'h0;
  assign INT          = 1'b0;
`endif

endmodule

// File: tb/tb_mio_bus.sv
// tb_mio_bus: directed self-checking bench for mio_bus with a synchronous RAM
// model. Counter checks are compiled in when MIO_COUNTER_EN is defined,
// otherwise region 0xF is checked as unmapped.

module tb_mio_bus;

  localparam int RAM_AW = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_req;
  logic              mem_w;
  logic [31:0]       Addr_out;
  logic [31:0]       Data_out;
  logic [31:0]       Data_in;
  logic              MIO_ready;
  logic              INT;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic              ram_we;
  logic [31:0]       ram_dout;
  logic [31:0]       gpio_in;
  logic [31:0]       gpio_out;

  int assertCount = 0;
  int failCount   = 0;
  int weCount     = 0;
  logic [RAM_AW-1:0] weAddr;
  logic [31:0]       weData;

  logic [31:0] ramMem [0:(1<<RAM_AW)-1];

  mio_bus #(.RAM_AW(RAM_AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_w     (mem_w),
    .Addr_out  (Addr_out),
    .Data_out  (Data_out),
    .Data_in   (Data_in),
    .MIO_ready (MIO_ready),
    .INT       (INT),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Synchronous RAM model with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_we) ramMem[ram_addr] <= ram_din;
    ram_dout <= ramMem[ram_addr];
  end

  // Records every RAM write strobe so pulse counts and addresses can be checked.
  always @(posedge clk) begin
    if (ram_we) begin
      weCount <= weCount + 1;
      weAddr  <= ram_addr;
      weData  <= ram_din;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data);
    mem_req  = req;
    mem_w    = wr;
    Addr_out = addr;
    Data_out = data;
  endtask

  // Write: the write edge is the first posedge; returns at a negedge in IDLE.
  task automatic busWrite(input string tag, input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b1, addr, data);
    @(negedge clk);
    checkOutput({tag, "_ready"}, {31'h0, MIO_ready}, 32'h1);
    mem_req = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_done"}, {31'h0, MIO_ready}, 32'h0);
  endtask

  // Read with an expected latency of 1 (register) or 2 (RAM) cycles.
  task automatic busRead(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                         input int lat);
    applyStimulus(1'b1, 1'b0, addr, 32'h0);
    if (lat == 2) begin
      @(negedge clk);
      checkOutput({tag, "_wait"}, {31'h0, MIO_ready}, 32'h0);
    end
    @(negedge clk);
    checkOutput({tag, "_ready"}, {31'h0, MIO_ready}, 32'h1);
    checkOutput({tag, "_data"}, Data_in, exp);
    mem_req = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_done"}, {31'h0, MIO_ready}, 32'h0);
  endtask

  // Main directed sequence.
  initial begin
    for (int i = 0; i < (1 << RAM_AW); i++) ramMem[i] = 32'h0;
    reset   = 1'b0;
    gpio_in = 32'h0000_1234;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", {31'h0, MIO_ready}, 32'h0);
    checkOutput("rst_data", Data_in, 32'h0);
    checkOutput("rst_gpio", gpio_out, 32'h0);
    checkOutput("rst_int", {31'h0, INT}, 32'h0);
    checkOutput("rst_we", {31'h0, ram_we}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] RAM accesses");
    busWrite("ram_wr", 32'h0000_0010, 32'hDEAD_BEEF);
    checkOutput("ram_we_count", weCount, 32'd1);
    checkOutput("ram_we_addr", {22'h0, weAddr}, 32'd4);
    checkOutput("ram_we_data", weData, 32'hDEAD_BEEF);
    checkOutput("wr_keeps_data", Data_in, 32'h0);
    busRead("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF, 2);
    busWrite("ram_wr_top", 32'h0000_0FFC, 32'h1234_5678);
    checkOutput("ram_we_count2", weCount, 32'd2);
    checkOutput("ram_we_addr2", {22'h0, weAddr}, 32'h3FF);
    busRead("ram_rd_top", 32'h0000_0FFC, 32'h1234_5678, 2);
    busRead("ram_rd_again", 32'h0000_0010, 32'hDEAD_BEEF, 2);

    $display("[TB] GPIO accesses");
    busWrite("gpio_wr", 32'hE000_0000, 32'h0000_00A5);
    checkOutput("gpio_out", gpio_out, 32'h0000_00A5);
    busRead("gpio_in_rd", 32'hE000_0004, 32'h0000_1234, 1);
    busWrite("gpio_in_wr", 32'hE000_0004, 32'hFFFF_FFFF);
    checkOutput("gpio_in_wr_drop", gpio_out, 32'h0000_00A5);
    busRead("gpio_out_rd", 32'hE000_0000, 32'h0000_00A5, 1);
    checkOutput("gpio_no_ram_we", weCount, 32'd2);

    $display("[TB] unmapped accesses");
    busRead("unmap_rd", 32'h5000_0000, 32'h0, 1);
    busWrite("unmap_wr", 32'h5000_0000, 32'h1111_1111);
    checkOutput("unmap_no_ram_we", weCount, 32'd2);

`ifdef MIO_COUNTER_EN
    $display("[TB] counter one-shot");
    busWrite("cnt_wr3", 32'hF000_0000, 32'd3);
    busWrite("ctrl_wr9", 32'hF000_0004, 32'h9);
    repeat (3) @(negedge clk);
    checkOutput("oneshot_int_lo", {31'h0, INT}, 32'h0);
    @(negedge clk);
    checkOutput("oneshot_int_hi", {31'h0, INT}, 32'h1);
    busRead("oneshot_ctrl", 32'hF000_0004, 32'hC, 1);
    busRead("oneshot_count", 32'hF000_0000, 32'h0, 1);
    busWrite("ctrl_clr", 32'hF000_0004, 32'h4);
    checkOutput("clr_int", {31'h0, INT}, 32'h0);
    busRead("clr_ctrl", 32'hF000_0004, 32'h0, 1);

    $display("[TB] counter auto-reload");
    busWrite("cnt_wr2", 32'hF000_0000, 32'd2);
    busWrite("ctrl_wrB", 32'hF000_0004, 32'hB);
    repeat (2) @(negedge clk);
    checkOutput("auto_int_lo", {31'h0, INT}, 32'h0);
    @(negedge clk);
    checkOutput("auto_int_hi", {31'h0, INT}, 32'h1);
    repeat (4) @(negedge clk);
    busWrite("w1c_at_uflow", 32'hF000_0004, 32'hF);
    busRead("w1c_ctrl", 32'hF000_0004, 32'hF, 1);
    busWrite("cnt_wr100", 32'hF000_0000, 32'd100);
    busRead("cnt_wins", 32'hF000_0000, 32'd99, 1);
    busWrite("ctrl_stop", 32'hF000_0004, 32'h4);
    checkOutput("stop_int", {31'h0, INT}, 32'h0);
    busRead("cnt_frozen", 32'hF000_0000, 32'd96, 1);

    $display("[TB] EN write during underflow");
    busWrite("cnt_wr0", 32'hF000_0000, 32'd0);
    busWrite("ctrl_wrB0", 32'hF000_0004, 32'hB);
    busWrite("ctrl_wr8", 32'hF000_0004, 32'h8);
    busRead("en_off_ctrl", 32'hF000_0004, 32'hC, 1);
    busWrite("ctrl_clr2", 32'hF000_0004, 32'h4);
`else
    $display("[TB] counter region unmapped");
    busRead("f_count_rd", 32'hF000_0000, 32'h0, 1);
    busWrite("f_ctrl_wr", 32'hF000_0004, 32'h9);
    busRead("f_ctrl_rd", 32'hF000_0004, 32'h0, 1);
    repeat (4) @(negedge clk);
    checkOutput("f_int", {31'h0, INT}, 32'h0);
`endif

    $display("[TB] reset during RAM read");
    busWrite("gpio_wr2", 32'hE000_0000, 32'h0000_005A);
    busRead("pre_rst_rd", 32'h0000_0010, 32'hDEAD_BEEF, 2);
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    @(negedge clk);
    checkOutput("rst_mid_wait", {31'h0, MIO_ready}, 32'h0);
    reset = 1'b0;
    #1;
    checkOutput("rst_mid_data", Data_in, 32'h0);
    checkOutput("rst_mid_gpio", gpio_out, 32'h0);
    checkOutput("rst_mid_ready", {31'h0, MIO_ready}, 32'h0);
    checkOutput("rst_mid_int", {31'h0, INT}, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0020, 32'h0000_CAFE);
    #1;
    checkOutput("rst_mid_we", {31'h0, ram_we}, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("rst_mid_we_count", weCount, 32'd2);
    checkOutput("rst_mid_ready2", {31'h0, MIO_ready}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_ready", {31'h0, MIO_ready}, 32'h0);
    checkOutput("post_rst_data", Data_in, 32'h0);
    busRead("post_rst_ram", 32'h0000_0020, 32'h0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
